serializer_gearbox: RTL and testbench
=====================================

Name: serializer_gearbox

Overview:
- Parametrised, fabric-only successor to the fixed 10b OSERDES-based serializer.
- Accepts WIDTH-bit encoded words over a valid/ready handshake into a DEPTH-entry FIFO.
- Shifts each word out OUT_W bits per step strobe, in LSB-first or MSB-first order.
- Inserts IDLE_WORD when the FIFO is empty at a word boundary, flags underflow, and marks word boundaries for downstream lane logic or a PHY gearbox.

Parameters:
- WIDTH, 10, parallel word width; WIDTH % OUT_W == 0 required.
- OUT_W, 1, serial bits emitted per step (1, 2, 5 or 10 for WIDTH=10).
- DEPTH, 4, input FIFO entries; power of 2, >= 2.
- LSB_FIRST, 1, 1 = bit 0 leaves first; 0 = bit WIDTH-1 leaves first.
- IDLE_WORD, 10'h17C, fill word (K28.5 RD-, a-bit at bit 0).

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  WIDTH  parallel word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO can accept; high when fill_level != DEPTH.
- step  in  1  advance strobe; one OUT_W slice per asserted cycle.
- ser_out  out  OUT_W  current serial slice, registered.
- word_start  out  1  ser_out holds slice 0 of a word.
- idle_out  out  1  current word is IDLE_WORD fill.
- underflow  out  1  one-cycle pulse when idle fill is forced after data.
- fill_level  out  $clog2(DEPTH+1)  FIFO occupancy.
- clr_cnt  in  1  synchronous clear of underflow_cnt.
- underflow_cnt  out  16  saturating underflow count.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled externally) sets:
  - FIFO empty; fill_level=0; s_ready=1.
  - Shifter loaded with IDLE_WORD, slice index N-1 so the next step loads a word, where N=WIDTH/OUT_W.
  - ser_out = first slice of IDLE_WORD in the selected order; word_start=1; idle_out=1.
  - underflow=0; underflow_cnt=0; armed=0.
- Push: s_valid && s_ready at an edge writes s_data to the tail. s_ready depends only on fill_level and never on s_valid.
- Shifting happens only on edges where step=1. The slice index k runs 0..N-1.
  - If k < N-1: k <= k+1, ser_out <= slice k+1, word_start <= 0.
  - If k == N-1 (word boundary): k <= 0, word_start <= 1, and the next word is loaded.
    - FIFO non-empty: pop the head word, idle_out <= 0, armed <= 1.
    - FIFO empty: load IDLE_WORD, idle_out <= 1. If armed=1, also pulse underflow for one cycle and increment underflow_cnt.
- ser_out shows the first slice of the newly loaded word on the same edge, so there are no bubbles.
- Slice j:
  - LSB_FIRST=1: word[j*OUT_W +: OUT_W], with bit 0 of the slice sent earliest.
  - LSB_FIRST=0: word[WIDTH-1-j*OUT_W -: OUT_W], with the MSB of the slice sent earliest.
- Latency: a word pushed into an empty FIFO at edge t is popped at the first step word boundary at an edge >= t+1. There is no same-edge bypass.
- Simultaneous push and pop:
  - The pop decision uses FIFO state before this edge's push. If the FIFO is empty, idle is loaded and the pushed word is stored; fill_level ends at 1.
  - If the FIFO is not full, push and pop in the same edge leave fill_level unchanged.
  - When full, s_ready=0 and a pop on that edge raises s_ready on the next cycle.
- step=0 holds all shifter outputs. Push continues.
- underflow_cnt saturates at 16'hFFFF. clr_cnt wins over a simultaneous increment, giving 0.
- Pointers wrap modulo DEPTH. fill_level never exceeds DEPTH.
- Reset mid-word discards the FIFO and the partial word immediately. After release, output restarts at IDLE_WORD slice 0.

Test Plan:
- Reset, step held 1, no data, WIDTH=10, OUT_W=1, LSB_FIRST=1 -> ser_out repeats 0,0,1,1,1,1,1,0,1,0; word_start every 10th cycle; idle_out=1; underflow never pulses (armed=0).
- Push 10'h2AA then 10'h155 with step=1, OUT_W=2 -> slices 2,2,2,2,2 then 1,1,1,1,1 back-to-back; idle_out=0; next word is idle with a single underflow pulse; underflow_cnt=1.
- Push 4 words with step=0 -> fill_level=4, s_ready=0. Assert step for one full word (10 steps) -> the pop happens at the boundary and s_ready=1 on the next cycle.
- LSB_FIRST=0, OUT_W=5, push 10'h3E0 -> slices 5'h1F then 5'h00.
- Underflow 3 times, then assert clr_cnt on the cycle of a 4th underflow -> underflow_cnt=0. Force underflow_cnt to 16'hFFFF plus one more underflow -> stays 16'hFFFF.
- Deassert rst_n mid-word with 2 words queued -> fill_level=0 and ser_out=IDLE slice 0 immediately; queued words are never emitted.

Source files
------------

// File: rtl/serializer_gearbox.sv
// Fabric gearbox: buffers WIDTH-bit encoded words in a small FIFO and shifts them out
// OUT_W bits per step, filling with IDLE_WORD and flagging underflow when starved.
module serializer_gearbox #(
  parameter int              WIDTH     = 10,
  parameter int              OUT_W     = 1,
  parameter int              DEPTH     = 4,
  parameter bit              LSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD = 10'h17C
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       step,
  output logic [OUT_W-1:0]           ser_out,
  output logic                       word_start,
  output logic                       idle_out,
  output logic                       underflow,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  input  logic                       clr_cnt,
  output logic [15:0]                underflow_cnt
);

  localparam int N  = WIDTH / OUT_W;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [KW-1:0] LAST_K = KW'(N - 1);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);

  // Slice j of a word in transmit order; the earliest bit sits at bit 0 (LSB-first)
  // or at the slice MSB (MSB-first).
  function automatic logic [OUT_W-1:0] get_slice(input logic [WIDTH-1:0] w,
                                                 input logic [KW-1:0]    j);
    logic [WIDTH-1:0] tmp;
    if (LSB_FIRST) begin
      tmp = w >> (int'(j) * OUT_W);
      return tmp[OUT_W-1:0];
    end else begin
      tmp = w << (int'(j) * OUT_W);
      return tmp[WIDTH-1 -: OUT_W];
    end
  endfunction

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r, count_next_s;
  logic             ready_r;
  logic [WIDTH-1:0] word_r;
  logic [KW-1:0]    k_r;
  logic [OUT_W-1:0] ser_r;
  logic             word_start_r, idle_r, underflow_r, armed_r;
  logic [15:0]      cnt_r;
  logic             push_s, boundary_s, pop_s, starve_s;
  logic [WIDTH-1:0] head_s;

  // Handshake, word-boundary decode and next FIFO occupancy.
  always_comb begin
    push_s       = s_valid && ready_r;
    boundary_s   = step && (k_r == LAST_K);
    pop_s        = boundary_s && (count_r != {CW{1'b0}});
    starve_s     = boundary_s && (count_r == {CW{1'b0}});
    head_s       = mem_r[rd_ptr_r];
    count_next_s = count_r;
    if (push_s && !pop_s) begin
      count_next_s = count_r + CW'(1);
    end else if (pop_s && !push_s) begin
      count_next_s = count_r - CW'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= s_data;
  end

  // FIFO pointers, shifter and underflow bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      ready_r      <= 1'b1;
      word_r       <= IDLE_WORD;
      k_r          <= LAST_K;
      ser_r        <= get_slice(IDLE_WORD, {KW{1'b0}});
      word_start_r <= 1'b1;
      idle_r       <= 1'b1;
      underflow_r  <= 1'b0;
      armed_r      <= 1'b0;
      cnt_r        <= 16'h0000;
    end else begin
      count_r     <= count_next_s;
      ready_r     <= (count_next_s != FULL);
      underflow_r <= 1'b0;
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (step) begin
        if (boundary_s) begin
          k_r          <= {KW{1'b0}};
          word_start_r <= 1'b1;
          if (pop_s) begin
            word_r   <= head_s;
            ser_r    <= get_slice(head_s, {KW{1'b0}});
            idle_r   <= 1'b0;
            armed_r  <= 1'b1;
            rd_ptr_r <= rd_ptr_r + AW'(1);
          end else begin
            word_r      <= IDLE_WORD;
            ser_r       <= get_slice(IDLE_WORD, {KW{1'b0}});
            idle_r      <= 1'b1;
            underflow_r <= armed_r;
            armed_r     <= 1'b0;
          end
        end else begin
          k_r          <= k_r + KW'(1);
          ser_r        <= get_slice(word_r, k_r + KW'(1));
          word_start_r <= 1'b0;
        end
      end
      // Clear beats a simultaneous increment; the count sticks at all-ones.
      if (clr_cnt) begin
        cnt_r <= 16'h0000;
      end else if (starve_s && armed_r && (cnt_r != 16'hFFFF)) begin
        cnt_r <= cnt_r + 16'd1;
      end
    end
  end

  assign s_ready       = ready_r;
  assign fill_level    = count_r;
  assign ser_out       = ser_r;
  assign word_start    = word_start_r;
  assign idle_out      = idle_r;
  assign underflow     = underflow_r;
  assign underflow_cnt = cnt_r;

endmodule

// File: tb/tb_serializer_gearbox.sv
// Directed bench: three gearbox configurations (1b LSB, 2b LSB, 5b MSB) checked
// against hand-computed slice sequences, FIFO levels and underflow counts.
module tb_serializer_gearbox;

  logic clk = 1'b0;
  logic rst_n, clr_cnt;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [9:0] s_data_a, s_data_b, s_data_c;
  logic s_valid_a, s_valid_b, s_valid_c;
  logic s_ready_a, s_ready_b, s_ready_c;
  logic step_a, step_b, step_c;
  logic [0:0] ser_a;
  logic [1:0] ser_b;
  logic [4:0] ser_c;
  logic ws_a, ws_b, ws_c, idle_a, idle_b, idle_c, uf_a, uf_b, uf_c;
  logic [2:0] fill_a, fill_b, fill_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;

  logic [9:0] idle_w = 10'h17C;
  logic [9:0] words [4] = '{10'h0F1, 10'h2AA, 10'h155, 10'h30C};
  logic [1:0] b_slices [2] = '{2'd2, 2'd1};

  serializer_gearbox #(.WIDTH(10), .OUT_W(1), .DEPTH(4), .LSB_FIRST(1'b1), .IDLE_WORD(10'h17C)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_a), .s_valid(s_valid_a), .s_ready(s_ready_a),
    .step(step_a), .ser_out(ser_a), .word_start(ws_a), .idle_out(idle_a), .underflow(uf_a),
    .fill_level(fill_a), .clr_cnt(clr_cnt), .underflow_cnt(cnt_a));

  serializer_gearbox #(.WIDTH(10), .OUT_W(2), .DEPTH(4), .LSB_FIRST(1'b1), .IDLE_WORD(10'h17C)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
    .step(step_b), .ser_out(ser_b), .word_start(ws_b), .idle_out(idle_b), .underflow(uf_b),
    .fill_level(fill_b), .clr_cnt(clr_cnt), .underflow_cnt(cnt_b));

  serializer_gearbox #(.WIDTH(10), .OUT_W(5), .DEPTH(4), .LSB_FIRST(1'b0), .IDLE_WORD(10'h17C)) dut_c (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_c), .s_valid(s_valid_c), .s_ready(s_ready_c),
    .step(step_c), .ser_out(ser_c), .word_start(ws_c), .idle_out(idle_c), .underflow(uf_c),
    .fill_level(fill_c), .clr_cnt(clr_cnt), .underflow_cnt(cnt_c));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entry: dut_a at the last slice with step low. Pushes one word, sends it, then
  // reaches the starved boundary (optionally with clr_cnt), and ends at the last slice.
  task automatic underflow_round(input logic do_clr, input logic [15:0] exp_cnt);
    step_a = 1'b0; s_valid_a = 1'b1; s_data_a = 10'h3FF;
    tick();
    check_val("round_fill", fill_a, 1);
    s_valid_a = 1'b0; step_a = 1'b1;
    tick();
    check_val("round_pop_idle", idle_a, 0);
    repeat (9) tick();
    clr_cnt = do_clr;
    tick();
    clr_cnt = 1'b0;
    check_val("round_uf", uf_a, 1);
    check_val("round_cnt", cnt_a, exp_cnt);
    repeat (9) tick();
    step_a = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr_cnt = 1'b0;
    s_data_a = '0; s_data_b = '0; s_data_c = '0;
    s_valid_a = 1'b0; s_valid_b = 1'b0; s_valid_c = 1'b0;
    step_a = 1'b0; step_b = 1'b0; step_c = 1'b0;
    repeat (2) tick();

    // Reset state
    check_val("rst_fill", fill_a, 0);
    check_val("rst_ready", s_ready_a, 1);
    check_val("rst_ser_a", ser_a, 0);
    check_val("rst_ser_b", ser_b, 0);
    check_val("rst_ser_c", ser_c, 5'h0B);
    check_val("rst_ws", ws_a, 1);
    check_val("rst_idle", idle_a, 1);
    check_val("rst_uf", uf_a, 0);
    check_val("rst_cnt", cnt_a, 0);

    // Idle stream, 1 bit per step: 0,0,1,1,1,1,1,0,1,0 repeating, no underflow
    rst_n = 1'b1; step_a = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick();
      check_val("idle_ser", ser_a, {31'd0, idle_w[j % 10]});
      check_val("idle_ws", ws_a, (j % 10 == 0) ? 1 : 0);
      check_val("idle_flag", idle_a, 1);
      check_val("idle_uf", uf_a, 0);
    end
    step_a = 1'b0;

    // OUT_W=2: 2AA then 155 back-to-back, then one underflow
    s_valid_b = 1'b1; s_data_b = 10'h2AA;
    tick();
    s_data_b = 10'h155;
    tick();
    check_val("b_fill", fill_b, 2);
    s_valid_b = 1'b0; step_b = 1'b1;
    for (int w = 0; w < 2; w++) begin
      for (int j = 0; j < 5; j++) begin
        tick();
        check_val("b_ser", ser_b, b_slices[w]);
        check_val("b_ws", ws_b, (j == 0) ? 1 : 0);
        check_val("b_idle", idle_b, 0);
      end
    end
    tick();
    check_val("b_uf_pulse", uf_b, 1);
    check_val("b_uf_idle", idle_b, 1);
    check_val("b_uf_ser", ser_b, 0);
    check_val("b_cnt", cnt_b, 1);
    tick();
    check_val("b_uf_clear", uf_b, 0);
    repeat (3) tick();
    tick();
    check_val("b_uf_once", uf_b, 0);
    check_val("b_cnt_once", cnt_b, 1);
    step_b = 1'b0;

    // OUT_W=5 MSB-first: 3E0 -> 1F, 00
    s_valid_c = 1'b1; s_data_c = 10'h3E0;
    tick();
    s_valid_c = 1'b0; step_c = 1'b1;
    tick();
    check_val("c_s0", ser_c, 5'h1F);
    check_val("c_ws0", ws_c, 1);
    tick();
    check_val("c_s1", ser_c, 5'h00);
    check_val("c_ws1", ws_c, 0);
    tick();
    check_val("c_idle_s0", ser_c, 5'h0B);
    check_val("c_uf", uf_c, 1);
    step_c = 1'b0;

    // Fill to DEPTH, refuse a fifth word, then drain
    for (int i = 0; i < 4; i++) begin
      s_valid_a = 1'b1; s_data_a = words[i];
      tick();
    end
    check_val("full_fill", fill_a, 4);
    check_val("full_ready", s_ready_a, 0);
    s_data_a = 10'h000;
    tick();
    check_val("full_hold", fill_a, 4);
    s_valid_a = 1'b0; step_a = 1'b1;
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < 10; j++) begin
        tick();
        check_val("drain_ser", ser_a, {31'd0, words[w][j]});
        check_val("drain_ws", ws_a, (j == 0) ? 1 : 0);
        check_val("drain_idle", idle_a, 0);
        if (w == 0 && j == 0) begin
          check_val("pop_fill", fill_a, 3);
          check_val("pop_ready", s_ready_a, 1);
        end
      end
    end
    tick();
    check_val("drain_uf", uf_a, 1);
    check_val("drain_uf_idle", idle_a, 1);
    check_val("drain_cnt", cnt_a, 1);
    repeat (9) tick();
    step_a = 1'b0;

    // Underflow count, clear-wins and saturation
    underflow_round(1'b0, 16'd2);
    underflow_round(1'b0, 16'd3);
    underflow_round(1'b1, 16'd0);
    force dut_a.cnt_r = 16'hFFFF;
    #1;
    release dut_a.cnt_r;
    #1;
    check_val("sat_forced", cnt_a, 16'hFFFF);
    underflow_round(1'b0, 16'hFFFF);

    // Reset mid-word with two words queued
    for (int i = 0; i < 3; i++) begin
      s_valid_a = 1'b1; s_data_a = words[i];
      tick();
    end
    s_valid_a = 1'b0; step_a = 1'b1;
    tick();
    check_val("mid_fill", fill_a, 2);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_fill", fill_a, 0);
    check_val("mid_rst_ser", ser_a, 0);
    check_val("mid_rst_ws", ws_a, 1);
    check_val("mid_rst_idle", idle_a, 1);
    check_val("mid_rst_ready", s_ready_a, 1);
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      check_val("post_rst_ser", ser_a, {31'd0, idle_w[j]});
      check_val("post_rst_idle", idle_a, 1);
    end
    step_a = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
